// File: rtl/distram_pkg.sv
// distram_pkg: constants shared by the distributed-RAM FIFO and its reader
package distram_pkg;
  localparam int DISTRAM_READ_LATENCY = 2;
endpackage

// File: rtl/distram_fifo_reader_if.sv
// distram_fifo_reader_if: FIFO read port plus downstream valid/ready stream
interface distram_fifo_reader_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  fifo_re;
  logic                  fifo_empty;
  logic                  fifo_valid;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;
  modport master (
    output fifo_re, m_valid, m_data,
    input  fifo_empty, fifo_valid, fifo_dout, m_ready
  );
  modport slave (
    input  fifo_re, m_valid, m_data,
    output fifo_empty, fifo_valid, fifo_dout, m_ready
  );
endinterface

// File: rtl/stream_reg_buf.sv
// stream_reg_buf: small register FIFO with simultaneous write/pop when full
module stream_reg_buf #(
  parameter int DATA_WIDTH = 64,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        wr,
  input  logic [DATA_WIDTH-1:0]       din,
  input  logic                        rd,
  output logic [DATA_WIDTH-1:0]       dout,
  output logic [$clog2(BUF_DEPTH):0]  occ,
  output logic                        full,
  output logic                        empty
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int OW = AW + 1;
  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_rd, do_wr;
  assign empty = occ == '0;
  assign full  = occ == OW'(BUF_DEPTH);
  assign do_rd = rd & ~empty;
  assign do_wr = wr & (~full | do_rd);
  assign dout  = mem[rp];
  always_ff @(posedge clk)
    if (!reset_n) begin
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) mem[wp] <= din;
      wp  <= wp + AW'(do_wr);
      rp  <= rp + AW'(do_rd);
      occ <= occ + OW'(do_wr) - OW'(do_rd);
    end
endmodule

// File: rtl/distram_fifo_reader.sv
// distram_fifo_reader: credit-based FIFO read adapter to a valid/ready stream
module distram_fifo_reader
  import distram_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int READ_LATENCY = DISTRAM_READ_LATENCY,
  parameter int BUF_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  distram_fifo_reader_if.master bus,
  output logic                  busy,
  output logic [31:0]           words_out,
  output logic                  protocol_err
);
  localparam int UW = $clog2(BUF_DEPTH) + 1;
  localparam int IW = $clog2(READ_LATENCY + 1);
  localparam logic [UW-1:0] DEPTH = UW'(BUF_DEPTH);
  logic [UW-1:0] used, occ;
  logic [IW-1:0] inflight;
  logic empty_q, full, buf_empty, pop;
  // used reserves a buffer slot per issued read, so a returning word always fits
  assign bus.fifo_re = reset_n & enable & ~bus.fifo_empty & ~empty_q & (used < DEPTH);
  assign bus.m_valid = occ != '0;
  assign pop         = bus.m_valid & bus.m_ready;
  assign busy        = (used != '0) | ~buf_empty;
  stream_reg_buf #(.DATA_WIDTH(DATA_WIDTH), .BUF_DEPTH(BUF_DEPTH)) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .wr      (bus.fifo_valid),
    .din     (bus.fifo_dout),
    .rd      (pop),
    .dout    (bus.m_data),
    .occ     (occ),
    .full    (full),
    .empty   (buf_empty)
  );
  always_ff @(posedge clk)
    if (!reset_n) begin
      empty_q      <= 1'b1;
      used         <= '0;
      inflight     <= '0;
      words_out    <= '0;
      protocol_err <= 1'b0;
    end else begin
      empty_q      <= bus.fifo_empty;
      used         <= (pop & ~bus.fifo_re & used == '0) ? used : used + UW'(bus.fifo_re) - UW'(pop);
      inflight     <= inflight + IW'(bus.fifo_re) - IW'(bus.fifo_valid & inflight != '0);
      words_out    <= words_out + 32'(pop);
      protocol_err <= protocol_err | (bus.fifo_valid & (inflight == '0 | (full & ~pop)));
    end
endmodule

// File: tb/tb_distram_fifo_reader.sv
// tb_distram_fifo_reader: FIFO model plus in-order stream scoreboard
module tb_distram_fifo_reader;
  logic clk = 0, reset_n = 0, enable = 0;
  logic busy, protocol_err;
  logic [31:0] words_out;
  int total = 0, bad = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_w;
  distram_fifo_reader_if #(.DATA_WIDTH(64)) bus();
  distram_fifo_reader #(.DATA_WIDTH(64), .BUF_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .bus(bus),
    .busy(busy), .words_out(words_out), .protocol_err(protocol_err)
  );
  always #5 clk = ~clk;
  // FIFO model: registered write, combinational empty, two-cycle read pipeline
  logic [63:0] fq[$];
  int fcnt = 0;
  logic p1v = 0, p2v = 0, wr_req = 0, inj = 0;
  logic [63:0] p1d = 0, p2d = 0, wr_data = 0, inj_data = 0;
  assign bus.fifo_empty = fcnt == 0;
  assign bus.fifo_valid = p2v | inj;
  assign bus.fifo_dout  = inj ? inj_data : p2d;
  always @(posedge clk)
    if (!reset_n) begin
      fq.delete();
      fcnt <= 0; p1v <= 0; p2v <= 0; p1d <= 0; p2d <= 0;
    end else begin
      p2v <= p1v;
      p2d <= p1d;
      p1v <= bus.fifo_re;
      if (bus.fifo_re) p1d <= fq.pop_front();
      if (wr_req) fq.push_back(wr_data);
      fcnt <= fcnt + (wr_req ? 1 : 0) - (bus.fifo_re ? 1 : 0);
    end
  always @(negedge clk)
    if (reset_n && bus.m_valid && bus.m_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL stream_extra got=%0h want=none", bus.m_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (bus.m_data !== exp_w) begin
          bad++;
          $display("FAIL stream_order got=%0h want=%0h", bus.m_data, exp_w);
        end
      end
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset_n = 0; enable = 0; wr_req = 0; inj = 0; bus.m_ready = 0;
    exp_q.delete();
    tick(); tick();
    reset_n = 1;
  endtask
  task automatic drain(output bit ok);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      ok = exp_q.size() == 0 && !busy;
    end
  endtask
  task automatic test_reset();
    reset_n = 0; enable = 1; bus.m_ready = 1; wr_req = 0; inj = 0;
    tick(); tick();
    @(negedge clk);
    total += 6;
    if (bus.fifo_re !== 1'b0) begin bad++; $display("FAIL rst_re got=%0b want=0", bus.fifo_re); end
    if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL rst_mvalid got=%0b want=0", bus.m_valid); end
    if (bus.m_data !== 64'h0) begin bad++; $display("FAIL rst_mdata got=%0h want=0", bus.m_data); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
    if (words_out !== 32'h0) begin bad++; $display("FAIL rst_words got=%0d want=0", words_out); end
    if (protocol_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b want=0", protocol_err); end
    tick();
    reset_n = 1;
  endtask
  task automatic test_basic();
    int first_re = -1, first_x = -1, last_x = -1, nx = 0;
    do_reset();
    enable = 1; bus.m_ready = 1;
    for (int i = 0; i < 24; i++) begin
      wr_req = i < 8;
      wr_data = 64'h10 + 64'(i);
      if (i < 8) exp_q.push_back(wr_data);
      @(negedge clk);
      if (bus.fifo_re && first_re < 0) first_re = i;
      if (bus.m_valid && bus.m_ready) begin
        if (first_x < 0) first_x = i;
        last_x = i;
        nx++;
      end
      tick();
    end
    wr_req = 0;
    @(negedge clk);
    total += 7;
    if (first_re !== 2) begin bad++; $display("FAIL basic_first_re got=%0d want=2", first_re); end
    if (first_x !== 5) begin bad++; $display("FAIL basic_first_xfer got=%0d want=5", first_x); end
    if (nx !== 8) begin bad++; $display("FAIL basic_xfers got=%0d want=8", nx); end
    if (last_x - first_x !== 7) begin bad++; $display("FAIL basic_b2b got=%0d want=7", last_x - first_x); end
    if (words_out !== 32'd8) begin bad++; $display("FAIL basic_words got=%0d want=8", words_out); end
    if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy got=%0b want=0", busy); end
    if (exp_q.size() !== 0) begin bad++; $display("FAIL basic_left got=%0d want=0", exp_q.size()); end
  endtask
  task automatic test_backpressure();
    int nre = 0;
    bit ok;
    do_reset();
    enable = 1; bus.m_ready = 0;
    for (int i = 0; i < 26; i++) begin
      wr_req = i < 16;
      wr_data = 64'h100 + 64'(i);
      if (i < 16) exp_q.push_back(wr_data);
      @(negedge clk);
      if (bus.fifo_re) nre++;
      tick();
    end
    wr_req = 0;
    @(negedge clk);
    total += 4;
    if (nre !== 4) begin bad++; $display("FAIL bp_re_count got=%0d want=4", nre); end
    if (bus.m_valid !== 1'b1) begin bad++; $display("FAIL bp_mvalid got=%0b want=1", bus.m_valid); end
    if (bus.m_data !== 64'h100) begin bad++; $display("FAIL bp_mdata got=%0h want=100", bus.m_data); end
    if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy got=%0b want=1", busy); end
    tick(); tick(); tick();
    @(negedge clk);
    total++;
    if (bus.m_data !== 64'h100 || bus.m_valid !== 1'b1) begin
      bad++; $display("FAIL bp_stable got=%0h/%0b want=100/1", bus.m_data, bus.m_valid);
    end
    tick();
    bus.m_ready = 1;
    drain(ok);
    total += 3;
    if (!ok) begin bad++; $display("FAIL bp_drain got=timeout want=drained"); end
    if (words_out !== 32'd16) begin bad++; $display("FAIL bp_words got=%0d want=16", words_out); end
    if (protocol_err !== 1'b0) begin bad++; $display("FAIL bp_err got=%0b want=0", protocol_err); end
  endtask
  task automatic test_toggle();
    bit ok;
    do_reset();
    enable = 1;
    for (int i = 0; i < 60; i++) begin
      wr_req = i < 16;
      wr_data = 64'h200 + 64'(i);
      if (i < 16) exp_q.push_back(wr_data);
      bus.m_ready = (i % 2) == 1;
      tick();
    end
    wr_req = 0; bus.m_ready = 1;
    drain(ok);
    total += 2;
    if (!ok) begin bad++; $display("FAIL tog_drain got=timeout want=drained"); end
    if (words_out !== 32'd16) begin bad++; $display("FAIL tog_words got=%0d want=16", words_out); end
  endtask
  task automatic test_enable();
    int nre = 0;
    bit ok;
    do_reset();
    enable = 0; bus.m_ready = 1;
    for (int i = 0; i < 10; i++) begin
      wr_req = i < 6;
      wr_data = 64'h300 + 64'(i);
      if (i < 6) exp_q.push_back(wr_data);
      @(negedge clk);
      if (bus.fifo_re) nre++;
      tick();
    end
    wr_req = 0;
    total += 2;
    if (nre !== 0) begin bad++; $display("FAIL en_off_re got=%0d want=0", nre); end
    if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL en_off_mvalid got=%0b want=0", bus.m_valid); end
    for (int i = 0; i < 10; i++) begin
      enable = i < 2;
      @(negedge clk);
      if (bus.fifo_re) nre++;
      tick();
    end
    @(negedge clk);
    total += 4;
    if (nre !== 2) begin bad++; $display("FAIL en_drop_re got=%0d want=2", nre); end
    if (words_out !== 32'd2) begin bad++; $display("FAIL en_drop_words got=%0d want=2", words_out); end
    if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL en_drop_mvalid got=%0b want=0", bus.m_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL en_drop_busy got=%0b want=0", busy); end
    tick();
    enable = 1;
    drain(ok);
    total += 2;
    if (!ok) begin bad++; $display("FAIL en_drain got=timeout want=drained"); end
    if (words_out !== 32'd6) begin bad++; $display("FAIL en_words got=%0d want=6", words_out); end
  endtask
  task automatic test_error();
    do_reset();
    inj = 1; inj_data = 64'hAA;
    exp_q.push_back(64'hAA);
    tick();
    inj = 0;
    @(negedge clk);
    total += 2;
    if (protocol_err !== 1'b1) begin bad++; $display("FAIL err_set got=%0b want=1", protocol_err); end
    if (bus.m_valid !== 1'b1 || bus.m_data !== 64'hAA) begin
      bad++; $display("FAIL err_word got=%0h/%0b want=aa/1", bus.m_data, bus.m_valid);
    end
    tick();
    bus.m_ready = 1;
    for (int i = 0; i < 5; i++) tick();
    @(negedge clk);
    total += 2;
    if (protocol_err !== 1'b1) begin bad++; $display("FAIL err_hold got=%0b want=1", protocol_err); end
    if (exp_q.size() !== 0) begin bad++; $display("FAIL err_stream got=%0d want=0", exp_q.size()); end
    tick();
    reset_n = 0;
    tick();
    @(negedge clk);
    total++;
    if (protocol_err !== 1'b0) begin bad++; $display("FAIL err_clear got=%0b want=0", protocol_err); end
    tick();
    reset_n = 1;
  endtask
  task automatic test_reset_mid();
    bit ok;
    do_reset();
    enable = 1; bus.m_ready = 0;
    for (int i = 0; i < 5; i++) begin
      wr_req = 1;
      wr_data = 64'h400 + 64'(i);
      exp_q.push_back(wr_data);
      tick();
    end
    wr_req = 0;
    reset_n = 0;
    exp_q.delete();
    @(negedge clk);
    total++;
    if (bus.fifo_re !== 1'b0) begin bad++; $display("FAIL mid_re got=%0b want=0", bus.fifo_re); end
    tick();
    @(negedge clk);
    total += 4;
    if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL mid_mvalid got=%0b want=0", bus.m_valid); end
    if (bus.m_data !== 64'h0) begin bad++; $display("FAIL mid_mdata got=%0h want=0", bus.m_data); end
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%0b want=0", busy); end
    if (words_out !== 32'h0) begin bad++; $display("FAIL mid_words got=%0d want=0", words_out); end
    tick();
    reset_n = 1;
    bus.m_ready = 1;
    for (int i = 0; i < 4; i++) begin
      wr_req = 1;
      wr_data = 64'h500 + 64'(i);
      exp_q.push_back(wr_data);
      tick();
    end
    wr_req = 0;
    drain(ok);
    total += 3;
    if (!ok) begin bad++; $display("FAIL mid_drain got=timeout want=drained"); end
    if (words_out !== 32'd4) begin bad++; $display("FAIL mid_restart_words got=%0d want=4", words_out); end
    if (protocol_err !== 1'b0) begin bad++; $display("FAIL mid_err got=%0b want=0", protocol_err); end
  endtask
  initial begin
    bus.m_ready = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_toggle();
    test_enable();
    test_error();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
